// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with two write ports, write-to-read bypass
// and a per-register busy scoreboard (set at issue, cleared at writeback).
module regfile_mp_sb #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NREGS    = 32,
   parameter int unsigned AW       = 5,
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic                     clk_i,
   input  logic                     reset_n,
   input  logic [NUM_RD*AW-1:0]     rd_addr_i,
   output logic [NUM_RD*XLEN-1:0]   rd_data_o,
   output logic [NUM_RD-1:0]        rd_busy_o,
   input  logic                     wr0_en_i,
   input  logic [AW-1:0]            wr0_addr_i,
   input  logic [XLEN-1:0]          wr0_data_i,
   input  logic                     wr1_en_i,
   input  logic [AW-1:0]            wr1_addr_i,
   input  logic [XLEN-1:0]          wr1_data_i,
   input  logic                     iss_en_i,
   input  logic [AW-1:0]            iss_addr_i,
   input  logic                     flush_i,
   output logic                     any_busy_o
);

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [XLEN-1:0]  regs_d [NREGS];
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;
   logic             wr0_act;
   logic             wr1_act;
   logic [AW-1:0]    ra;
   logic             hit0;
   logic             hit1;
   logic             is_zero;

   // Writes are qualified by reset so the bypass shows zero while reset is held.
   always_comb begin
      wr0_act = wr0_en_i & reset_n;
      wr1_act = wr1_en_i & reset_n;
   end

   always_comb begin
      regs_d = regs_q;
      if (wr0_act) regs_d[wr0_addr_i] = wr0_data_i;
      if (wr1_act) regs_d[wr1_addr_i] = wr1_data_i;
      if (ZERO_REG != 0) regs_d[0] = '0;
   end

   // Later steps override earlier ones: a new issue wins over writeback and flush.
   always_comb begin
      busy_d = busy_q;
      if (flush_i) busy_d = '0;
      if (wr0_act) busy_d[wr0_addr_i] = 1'b0;
      if (wr1_act) busy_d[wr1_addr_i] = 1'b0;
      if (iss_en_i) busy_d[iss_addr_i] = 1'b1;
      if (ZERO_REG != 0) busy_d[0] = 1'b0;
   end

   always_comb begin
      rd_data_o = '0;
      rd_busy_o = '0;
      ra        = '0;
      hit0      = 1'b0;
      hit1      = 1'b0;
      is_zero   = 1'b0;
      for (int unsigned k = 0; k < NUM_RD; k++) begin
         ra      = rd_addr_i[k*AW +: AW];
         hit0    = wr0_act && (wr0_addr_i == ra);
         hit1    = wr1_act && (wr1_addr_i == ra);
         is_zero = (ZERO_REG != 0) && (ra == '0);
         if (is_zero)   rd_data_o[k*XLEN +: XLEN] = '0;
         else if (hit1) rd_data_o[k*XLEN +: XLEN] = wr1_data_i;
         else if (hit0) rd_data_o[k*XLEN +: XLEN] = wr0_data_i;
         else           rd_data_o[k*XLEN +: XLEN] = regs_q[ra];
         rd_busy_o[k] = busy_q[ra] & ~hit0 & ~hit1 & ~is_zero;
      end
   end

   always_comb begin
      any_busy_o = |busy_q;
   end

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         regs_q <= '{default: '0};
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Randomized self-checking bench for regfile_mp_sb: a default instance and a
// 4-read-port 64-bit instance share stimulus and one behavioural model.
module tb_regfile_mp_sb;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [19:0]  ra;
   logic         we0, we1, iss, flush;
   logic [4:0]   wa0, wa1, ia;
   logic [63:0]  wd0, wd1;
   logic [63:0]  rd_a;
   logic [1:0]   bs_a;
   logic         ab_a;
   logic [255:0] rd_b;
   logic [3:0]   bs_b;
   logic         ab_b;

   logic [63:0]  mem [32];
   bit           bz  [32];
   int           vectors = 0;
   int           miscompares = 0;

   always #5 clk = ~clk;

   regfile_mp_sb #(.XLEN(32), .NREGS(32), .AW(5), .NUM_RD(2), .ZERO_REG(1)) dut_a (
      .clk_i(clk), .reset_n(rst_n), .rd_addr_i(ra[9:0]), .rd_data_o(rd_a), .rd_busy_o(bs_a),
      .wr0_en_i(we0), .wr0_addr_i(wa0), .wr0_data_i(wd0[31:0]),
      .wr1_en_i(we1), .wr1_addr_i(wa1), .wr1_data_i(wd1[31:0]),
      .iss_en_i(iss), .iss_addr_i(ia), .flush_i(flush), .any_busy_o(ab_a));

   regfile_mp_sb #(.XLEN(64), .NREGS(32), .AW(5), .NUM_RD(4), .ZERO_REG(1)) dut_b (
      .clk_i(clk), .reset_n(rst_n), .rd_addr_i(ra), .rd_data_o(rd_b), .rd_busy_o(bs_b),
      .wr0_en_i(we0), .wr0_addr_i(wa0), .wr0_data_i(wd0),
      .wr1_en_i(we1), .wr1_addr_i(wa1), .wr1_data_i(wd1),
      .iss_en_i(iss), .iss_addr_i(ia), .flush_i(flush), .any_busy_o(ab_b));

   function automatic logic [63:0] exp_rd(input logic [4:0] a);
      if (!rst_n || a == 5'd0) return 64'd0;
      if (we1 && wa1 == a) return wd1;
      if (we0 && wa0 == a) return wd0;
      return mem[a];
   endfunction

   function automatic logic exp_busy(input logic [4:0] a);
      if (!rst_n || a == 5'd0) return 1'b0;
      if ((we1 && wa1 == a) || (we0 && wa0 == a)) return 1'b0;
      return bz[a];
   endfunction

   function automatic logic exp_any();
      logic r = 1'b0;
      if (!rst_n) return 1'b0;
      for (int i = 0; i < 32; i++) r = r | bz[i];
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) begin
         mem[i] = 64'd0;
         bz[i]  = 1'b0;
      end
   endtask

   // Registered state after a rising edge, from the architectural rules.
   task automatic model_edge();
      if (!rst_n) begin
         model_clear();
      end else begin
         for (int r = 1; r < 32; r++) begin
            bit wr_hit = (we0 && wa0 == 5'(r)) || (we1 && wa1 == 5'(r));
            if (iss && ia == 5'(r))  bz[r] = 1'b1;
            else if (wr_hit)         bz[r] = 1'b0;
            else if (flush)          bz[r] = 1'b0;
         end
         if (we0 && wa0 != 5'd0) mem[wa0] = wd0;
         if (we1 && wa1 != 5'd0) mem[wa1] = wd1;
      end
   endtask

   task automatic compare_all();
      logic [4:0]  a;
      logic [63:0] e;
      for (int k = 0; k < 4; k++) begin
         a = ra[k*5 +: 5];
         e = exp_rd(a);
         chk($sformatf("B rd_data[%0d] x%0d", k, a), rd_b[k*64 +: 64], e);
         chk($sformatf("B rd_busy[%0d] x%0d", k, a), 64'(bs_b[k]), 64'(exp_busy(a)));
         if (k < 2) begin
            chk($sformatf("A rd_data[%0d] x%0d", k, a), 64'(rd_a[k*32 +: 32]), 64'(e[31:0]));
            chk($sformatf("A rd_busy[%0d] x%0d", k, a), 64'(bs_a[k]), 64'(exp_busy(a)));
         end
      end
      chk("A any_busy", 64'(ab_a), 64'(exp_any()));
      chk("B any_busy", 64'(ab_b), 64'(exp_any()));
   endtask

   task automatic cycle();
      @(negedge clk);
      compare_all();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      we0 = 1'b0; we1 = 1'b0; iss = 1'b0; flush = 1'b0;
   endtask

   initial begin
      model_clear();
      rst_n = 1'b0;
      idle();
      wa0 = '0; wa1 = '0; ia = '0; wd0 = '0; wd1 = '0;
      ra = {5'd5, 5'd31, 5'd31, 5'd5};
      cycle();
      cycle();
      chk("reset x5 data", 64'(rd_a[31:0]), 64'h0);
      chk("reset x31 data", 64'(rd_a[63:32]), 64'h0);
      chk("reset busy", 64'(bs_a), 64'h0);
      chk("reset any_busy", 64'(ab_b), 64'h0);

      rst_n = 1'b1;
      we0 = 1'b1; wa0 = 5'd7; wd0 = 64'hDEADBEEF;
      cycle();
      idle();
      ra = {5'd7, 5'd7, 5'd7, 5'd7};
      #1;
      chk("x7 port0", 64'(rd_a[31:0]), 64'hDEADBEEF);
      chk("x7 port1", 64'(rd_a[63:32]), 64'hDEADBEEF);
      chk("x7 wide", rd_b[63:0], 64'hDEADBEEF);
      we0 = 1'b1; wa0 = 5'd0; wd0 = 64'h1234;
      cycle();
      idle();
      ra[4:0] = 5'd0;
      #1;
      chk("x0 reads zero", 64'(rd_a[31:0]), 64'h0);

      we0 = 1'b1; wa0 = 5'd3; wd0 = 64'hAAAA;
      we1 = 1'b1; wa1 = 5'd3; wd1 = 64'h5555;
      ra[4:0] = 5'd3;
      #1;
      chk("x3 bypass wr1 wins", 64'(rd_a[31:0]), 64'h5555);
      cycle();
      idle();
      #1;
      chk("x3 stored", 64'(rd_a[31:0]), 64'h5555);

      iss = 1'b1; ia = 5'd9;
      cycle();
      idle();
      ra[4:0] = 5'd9;
      #1;
      chk("x9 busy after issue", 64'(bs_a[0]), 64'h1);
      chk("any_busy after issue", 64'(ab_a), 64'h1);
      we1 = 1'b1; wa1 = 5'd9; wd1 = 64'h99;
      #1;
      chk("x9 busy bypassed", 64'(bs_a[0]), 64'h0);
      chk("x9 data bypassed", 64'(rd_a[31:0]), 64'h99);
      cycle();
      idle();
      #1;
      chk("x9 busy cleared", 64'(bs_a[0]), 64'h0);
      iss = 1'b1; ia = 5'd9; we0 = 1'b1; wa0 = 5'd9; wd0 = 64'h42;
      cycle();
      idle();
      #1;
      chk("x9 issue beats write", 64'(bs_a[0]), 64'h1);

      for (int i = 0; i < 3; i++) begin
         iss = 1'b1; ia = 5'(2 + 2*i);
         cycle();
      end
      idle();
      flush = 1'b1; iss = 1'b1; ia = 5'd8;
      cycle();
      idle();
      ra = {5'd8, 5'd6, 5'd4, 5'd2};
      #1;
      chk("flush busy map", 64'(bs_b), 64'h8);
      chk("flush any_busy", 64'(ab_b), 64'h1);

      for (int n = 0; n < 3000; n++) begin
         we0   = 1'($urandom_range(0, 1));
         we1   = 1'($urandom_range(0, 2) == 0);
         iss   = 1'($urandom_range(0, 2) == 0);
         flush = 1'($urandom_range(0, 40) == 0);
         wa0   = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
         wa1   = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
         ia    = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
         wd0   = {$urandom, $urandom};
         wd1   = {$urandom, $urandom};
         for (int k = 0; k < 4; k++)
            ra[k*5 +: 5] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
         cycle();
      end

      idle();
      we0 = 1'b1; wa0 = 5'd10; wd0 = 64'h77;
      iss = 1'b1; ia = 5'd11;
      cycle();
      idle();
      we0 = 1'b1; wa0 = 5'd10; wd0 = 64'hCAFE_F00D_1234_5678;
      ra = {5'd10, 5'd10, 5'd11, 5'd10};
      #1;
      chk("x10 pending bypass", rd_b[63:0], 64'hCAFE_F00D_1234_5678);
      chk("x11 busy before reset", 64'(bs_a[1]), 64'h1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("x10 zero in reset A", 64'(rd_a[31:0]), 64'h0);
      chk("x10 zero in reset B", rd_b[63:0], 64'h0);
      chk("busy zero in reset", 64'(bs_b), 64'h0);
      chk("any_busy zero in reset", 64'(ab_a | ab_b), 64'h0);
      cycle();
      rst_n = 1'b1;
      idle();
      cycle();
      chk("x10 after reset", rd_b[63:0], 64'h0);
      chk("x11 busy after reset", 64'(bs_a[1]), 64'h0);
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
